// File: rtl/hilo_div_unit_pkg.sv
// Shared defines for the HI/LO unit: MIPS funct codes, HI/LO request codes
// and the divider state encoding.
package hilo_div_unit_pkg;

  localparam logic [5:0] EXE_MFHI  = 6'b010000;
  localparam logic [5:0] EXE_MTHI  = 6'b010001;
  localparam logic [5:0] EXE_MFLO  = 6'b010010;
  localparam logic [5:0] EXE_MTLO  = 6'b010011;
  localparam logic [5:0] EXE_MULT  = 6'b011000;
  localparam logic [5:0] EXE_MULTU = 6'b011001;
  localparam logic [5:0] EXE_DIV   = 6'b011010;
  localparam logic [5:0] EXE_DIVU  = 6'b011011;

  // Request codes driven by the decoder; 6 and 7 are deliberate no-ops.
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } hilo_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } div_state_e;

  localparam logic [5:0] DIV_LAST_STEP = 6'd31;

endpackage

// File: rtl/div_core.sv
// Iterative radix-2 restoring divider: 32 RUN steps on magnitudes, then a
// FIX cycle that applies sign correction and presents the result.
module div_core
  import hilo_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        is_signed,
  input  logic        flush,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        wr,
  output logic [31:0] quo,
  output logic [31:0] rem
);

  div_state_e  state;
  logic [5:0]  cnt;
  logic [31:0] q_reg;
  logic [31:0] r_reg;
  logic [31:0] dvs;
  logic        neg_q;
  logic        neg_r;
  logic        dz;

  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] shifted;
  logic        ge;
  logic [31:0] rsub;

  assign mag_a   = (is_signed && a[31]) ? (~a + 32'd1) : a;
  assign mag_b   = (is_signed && b[31]) ? (~b + 32'd1) : b;
  // q_reg doubles as the dividend shift register; its MSB feeds the remainder.
  assign shifted = {r_reg, q_reg[31]};
  assign ge      = (shifted >= {1'b0, dvs});
  assign rsub    = shifted[31:0] - dvs;

  assign busy = (state != ST_IDLE);
  assign wr   = (state == ST_FIX) && !flush;
  assign quo  = (!dz && neg_q) ? (~q_reg + 32'd1) : q_reg;
  assign rem  = (!dz && neg_r) ? (~r_reg + 32'd1) : r_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      cnt   <= '0;
      q_reg <= '0;
      r_reg <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            cnt <= '0;
            if (b == 32'd0) begin
              // Divide by zero bypasses RUN; result is preloaded raw.
              dz    <= 1'b1;
              q_reg <= '1;
              r_reg <= a;
              dvs   <= '0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= ST_FIX;
            end else begin
              dz    <= 1'b0;
              q_reg <= mag_a;
              r_reg <= '0;
              dvs   <= mag_b;
              neg_q <= is_signed && (a[31] ^ b[31]);
              neg_r <= is_signed && a[31];
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            q_reg <= {q_reg[30:0], ge};
            r_reg <= ge ? rsub : shifted[31:0];
            cnt   <= cnt + 6'd1;
            if (cnt == DIV_LAST_STEP) state <= ST_FIX;
          end
        end
        ST_FIX: begin
          state <= ST_IDLE;
          done  <= !flush;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/hilo_div_unit.sv
// HI/LO register file with single-cycle multiply and MTHI/MTLO, and an
// iterative divider that stalls the pipeline while it runs.
module hilo_div_unit
  import hilo_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  hilo_op_e    opc;
  logic        accept;
  logic        div_go;
  logic        div_signed;
  logic        div_wr;
  logic [31:0] div_quo;
  logic [31:0] div_rem;
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  assign opc        = hilo_op_e'(op);
  assign accept     = start && !flush && !busy;
  assign div_signed = (opc == OP_DIV);
  assign div_go     = accept && ((opc == OP_DIV) || (opc == OP_DIVU));

  // Sign-extending to 64 bits lets one unsigned multiply give the signed product.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  div_core u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (div_go),
    .is_signed (div_signed),
    .flush     (flush),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .wr        (div_wr),
    .quo       (div_quo),
    .rem       (div_rem)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi <= '0;
      lo <= '0;
    end else if (accept) begin
      case (opc)
        OP_MULT:  {hi, lo} <= prod_s;
        OP_MULTU: {hi, lo} <= prod_u;
        OP_MTHI:  hi <= a;
        OP_MTLO:  lo <= a;
        default:  ;
      endcase
    end else if (div_wr) begin
      hi <= div_rem;
      lo <= div_quo;
    end
  end

endmodule

// File: tb/tb_hilo_div_unit.sv
// Directed bench for hilo_div_unit: vector table for each op, plus hand
// sequences for flush, busy-time requests and mid-divide reset.
module tb_hilo_div_unit;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int nCompared;
  int nMismatched;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    int          expBusy;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  hilo_div_unit dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] av,
                               input logic [31:0] bv);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (busy && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  initial begin
    int cycles;
    logic doneSeen;
    logic [31:0] curHi;
    logic [31:0] curLo;

    nCompared   = 0;
    nMismatched = 0;
    resetn = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    op     = 3'd0;
    a      = '0;
    b      = '0;

    vecs[0]  = '{3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 0};
    vecs[1]  = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 0};
    vecs[2]  = '{3'd4, 32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 32'hFFFFFFFA, 0};
    vecs[3]  = '{3'd5, 32'h00001234, 32'd0,        32'hDEADBEEF, 32'h00001234, 0};
    vecs[4]  = '{3'd6, 32'h00000001, 32'd2,        32'hDEADBEEF, 32'h00001234, 0};
    vecs[5]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[6]  = '{3'd3, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1};
    vecs[7]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
    vecs[8]  = '{3'd3, 32'd1000,     32'd7,        32'd6,        32'd142,      33};
    vecs[9]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33};
    vecs[10] = '{3'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        33};
    vecs[11] = '{3'd3, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 33};
    vecs[12] = '{3'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1};
    vecs[13] = '{3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 0};
    vecs[14] = '{3'd7, 32'h00000055, 32'd9,        32'h3FFFFFFF, 32'h00000001, 0};
    vecs[15] = '{3'd3, 32'd3,        32'd5,        32'd3,        32'd0,        33};

    #1;
    checkOutput("reset hi", hi, 32'd0);
    checkOutput("reset lo", lo, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      waitIdle(cycles);
      checkOutput($sformatf("v%0d busy cycles", i), 32'(cycles), 32'(vecs[i].expBusy));
      checkOutput($sformatf("v%0d done", i), {31'd0, done},
                  {31'd0, (vecs[i].expBusy > 0)});
      @(negedge clk);
      checkOutput($sformatf("v%0d done width", i), {31'd0, done}, 32'd0);
      checkOutput($sformatf("v%0d hi", i), hi, vecs[i].expHi);
      checkOutput($sformatf("v%0d lo", i), lo, vecs[i].expLo);
    end
    curHi = vecs[NVEC-1].expHi;
    curLo = vecs[NVEC-1].expLo;

    // Flush in the tenth RUN cycle aborts the divide without touching HI/LO.
    applyStimulus(3'd3, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    checkOutput("flush busy before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush busy after", {31'd0, busy}, 32'd0);
    checkOutput("flush hi", hi, curHi);
    checkOutput("flush lo", lo, curLo);
    doneSeen = 1'b0;
    repeat (40) begin
      if (done) doneSeen = 1'b1;
      @(negedge clk);
    end
    checkOutput("flush no done", {31'd0, doneSeen}, 32'd0);
    checkOutput("flush hi later", hi, curHi);
    applyStimulus(3'd5, 32'h00001234, 32'd0);
    checkOutput("mtlo after flush", lo, 32'h00001234);
    checkOutput("mtlo after flush hi", hi, curHi);

    // MTHI presented during a divide must be dropped.
    applyStimulus(3'd3, 32'd1000, 32'd7);
    repeat (3) @(negedge clk);
    start = 1'b1;
    op    = 3'd4;
    a     = 32'h0000AAAA;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy mthi hi", hi, curHi);
    checkOutput("busy mthi still busy", {31'd0, busy}, 32'd1);
    waitIdle(cycles);
    checkOutput("busy mthi remaining", 32'(cycles), 32'd29);
    checkOutput("busy mthi result hi", hi, 32'd6);
    checkOutput("busy mthi result lo", lo, 32'd142);

    // Flush and start together in IDLE: nothing is accepted.
    @(negedge clk);
    flush = 1'b1;
    start = 1'b1;
    op    = 3'd4;
    a     = 32'h00005555;
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    checkOutput("flush+start hi", hi, 32'd6);
    checkOutput("flush+start busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    flush = 1'b1;
    start = 1'b1;
    op    = 3'd2;
    a     = 32'd50;
    b     = 32'd5;
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    checkOutput("flush+div busy", {31'd0, busy}, 32'd0);

    // Reset mid-RUN clears everything asynchronously.
    applyStimulus(3'd2, 32'hFFFFFFF9, 32'd2);
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    #1;
    checkOutput("midreset hi", hi, 32'd0);
    checkOutput("midreset lo", lo, 32'd0);
    checkOutput("midreset busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset done", {31'd0, done}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    applyStimulus(3'd0, 32'd6, 32'd7);
    checkOutput("post reset mult lo", lo, 32'd42);
    checkOutput("post reset mult hi", hi, 32'd0);
    applyStimulus(3'd3, 32'd1000, 32'd7);
    waitIdle(cycles);
    checkOutput("post reset div cycles", 32'(cycles), 32'd33);
    checkOutput("post reset div lo", lo, 32'd142);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
